// File: rtl/keypad_pkg.sv
// Shared types and constants for the microwave keypad time-entry front end.
package keypad_pkg;

  // Press-tracking FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEBOUNCE  = 2'd1,
    HELD      = 2'd2,
    WAIT_LOAD = 2'd3
  } state_t;

  localparam int         NUM_KEYS     = 10;
  localparam int         START_BIT    = 10;
  localparam int         PAT_W        = NUM_KEYS + 1;
  localparam int         MAX_DIGITS   = 3;
  localparam logic [3:0] MAX_SEC_TENS = 4'd5;

  // Converts a one-hot digit key vector into its BCD digit value
  function automatic logic [3:0] onehot_to_digit(input logic [NUM_KEYS-1:0] key_vec);
    logic [3:0] digit;
    digit = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_vec[i]) digit = 4'(i);
    end
    return digit;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes the raw keys, waits for a key pattern to hold steady for
// DEBOUNCE_CYCLES cycles and emits a single accept pulse per press. Release
// tracking holds off new presses until all keys are up and any pending
// transfer (i_load_busy) has completed.
module key_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [NUM_KEYS-1:0] i_keys,
  input  logic             i_start_key,
  input  logic             i_load_busy,
  output logic             o_accept_pulse,
  output logic [PAT_W-1:0] o_accept_pattern
);

  logic [PAT_W-1:0] w_raw;
  logic [PAT_W-1:0] r_meta;
  logic [PAT_W-1:0] r_sync;
  logic [PAT_W-1:0] w_p;
  logic [PAT_W-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  state_t           w_state_next;
  logic             w_match;
  logic             w_cnt_done;
  logic             w_any;

  assign w_raw      = {i_start_key, i_keys};
  assign w_p        = r_sync;
  assign w_any      = (w_p != '0);
  assign w_match    = (w_p == r_cand);
  assign w_cnt_done = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Two-flop synchronizer on the whole 11-bit key pattern
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Candidate capture in IDLE and stability counting in DEBOUNCE
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (r_state == IDLE) begin
      r_cand <= w_p;
      r_cnt  <= '0;
    end else if (r_state == DEBOUNCE && w_match && !w_cnt_done) begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  // Next-state logic; a bounce during DEBOUNCE restarts from IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (w_any) w_state_next = DEBOUNCE;
      DEBOUNCE: begin
        if (!w_match)        w_state_next = IDLE;
        else if (w_cnt_done) w_state_next = HELD;
      end
      HELD:      if (!w_any) w_state_next = i_load_busy ? WAIT_LOAD : IDLE;
      WAIT_LOAD: if (!w_any && !i_load_busy) w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  // Accept pulse fires on the last stable debounce cycle only
  always_comb begin
    o_accept_pulse   = (r_state == DEBOUNCE) && w_match && w_cnt_done;
    o_accept_pattern = r_cand;
  end

endmodule

// File: rtl/keypad_time_entry.sv
// Microwave timer keypad front end: digits shift in from the right into
// mins/sec_tens/sec_ones, start requests a transfer via load_valid/load_ready.
module keypad_time_entry
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                start_key,
  input  logic                clear,
  input  logic                enable,
  input  logic                load_ready,
  output logic [3:0]          sec_ones,
  output logic [3:0]          sec_tens,
  output logic [3:0]          mins,
  output logic                load_valid,
  output logic                entry_error
);

  logic             w_accept;
  logic [PAT_W-1:0] w_pattern;
  logic             w_is_digit;
  logic             w_is_start;
  logic             w_time_ok;
  logic             w_room;
  logic             w_act;
  logic [3:0]       w_digit;

  logic [3:0] r_sec_ones;
  logic [3:0] r_sec_tens;
  logic [3:0] r_mins;
  logic [1:0] r_digit_count;
  logic       r_load_valid;
  logic       r_entry_error;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debouncer (
    .clk              (clk),
    .i_reset          (reset),
    .i_keys           (keys),
    .i_start_key      (start_key),
    .i_load_busy      (r_load_valid),
    .o_accept_pulse   (w_accept),
    .o_accept_pattern (w_pattern)
  );

  // Exactly one digit key and no start key counts as a digit press
  assign w_is_digit = !w_pattern[START_BIT] && $onehot(w_pattern[NUM_KEYS-1:0]);
  assign w_is_start = w_pattern[START_BIT] && (w_pattern[NUM_KEYS-1:0] == '0);
  assign w_digit    = onehot_to_digit(w_pattern[NUM_KEYS-1:0]);
  assign w_room     = (r_digit_count < 2'(MAX_DIGITS));
  assign w_time_ok  = ({r_mins, r_sec_tens, r_sec_ones} != 12'd0) &&
                      (r_sec_tens <= MAX_SEC_TENS);
  // Accepted presses are dropped while disabled or while a transfer is pending
  assign w_act      = w_accept && enable && !r_load_valid;

  // Digit shift register, handshake and error pulse; clear beats handshake beats key
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sec_ones    <= 4'd0;
      r_sec_tens    <= 4'd0;
      r_mins        <= 4'd0;
      r_digit_count <= 2'd0;
      r_load_valid  <= 1'b0;
      r_entry_error <= 1'b0;
    end else begin
      r_entry_error <= 1'b0;
      if (clear || (r_load_valid && load_ready)) begin
        r_sec_ones    <= 4'd0;
        r_sec_tens    <= 4'd0;
        r_mins        <= 4'd0;
        r_digit_count <= 2'd0;
        r_load_valid  <= 1'b0;
      end else if (w_act) begin
        if (w_is_digit && w_room) begin
          r_mins        <= r_sec_tens;
          r_sec_tens    <= r_sec_ones;
          r_sec_ones    <= w_digit;
          r_digit_count <= r_digit_count + 2'd1;
        end else if (w_is_start) begin
          if (w_time_ok) r_load_valid  <= 1'b1;
          else           r_entry_error <= 1'b1;
        end
      end
    end
  end

  assign sec_ones    = r_sec_ones;
  assign sec_tens    = r_sec_tens;
  assign mins        = r_mins;
  assign load_valid  = r_load_valid;
  assign entry_error = r_entry_error;

endmodule
